alu_decode_stage: RTL

- Decode stage that turns RV32I integer instructions into the 4-bit ALU op codes and operand selects consumed by the execute-stage ALU.
- Sits between fetch (upstream valid/ready) and execute (downstream valid/ready).
- Registered output with a one-entry skid buffer, so full throughput is kept while o_ready stays a registered signal.
- Supports pipeline flush.

---
 rtl/alu_decode_stage_pkg.sv | 55 +++++
 rtl/alu_dec_comb.sv | 79 +++++++
 rtl/alu_decode_stage.sv | 91 +++++++++
 3 files changed

// File: rtl/alu_decode_stage_pkg.sv
// Shared ALU definitions: op codes, RV32I opcode constants and the decoded bundle
// passed from the decode stage to the execute-stage ALU.
package alu_decode_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLT  = 4'h2,
    ALU_SLTU = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_AND  = 4'h6,
    ALU_SLL  = 4'h7,
    ALU_SRL  = 4'h8,
    ALU_SRA  = 4'h9,
    ALU_LUI  = 4'hA
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam int DEC_PC_W = 32;

  typedef struct packed {
    alu_op_e               alu_op;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [31:0]           imm;
    logic                  use_imm;
    logic                  use_pc;
    logic                  illegal;
    logic [DEC_PC_W-1:0]   pc;
  } dec_bundle_t;

  // funct3 -> op for the funct7=0000000 (non-alternate) encodings
  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_dec_comb.sv
// Combinational RV32I integer decoder: instruction + pc -> dec_bundle_t.
// ALU_DEC_ILLEGAL_EN: when defined, illegal encodings raise the illegal flag.
module alu_dec_comb
  import alu_decode_stage_pkg::*;
(
  input  logic [31:0]         instr,
  input  logic [DEC_PC_W-1:0] pc,
  output dec_bundle_t         bundle
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] imm_sh;
  logic        ill;

  assign opc    = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'h000};
  assign imm_sh = {27'd0, instr[24:20]};

  always_comb begin
    bundle         = '0;
    bundle.alu_op  = ALU_ADD;
    bundle.rs1     = instr[19:15];
    bundle.rs2     = instr[24:20];
    bundle.rd      = instr[11:7];
    bundle.pc      = pc;
    ill            = 1'b0;
    case (opc)
      OPC_OP: begin
        if (f7 == F7_BASE)                      bundle.alu_op = base_op(f3);
        else if (f7 == F7_ALT && f3 == 3'b000) bundle.alu_op = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) bundle.alu_op = ALU_SRA;
        else                                    ill = 1'b1;
      end
      OPC_OP_IMM: begin
        bundle.use_imm = 1'b1;
        bundle.imm     = imm_i;
        bundle.alu_op  = base_op(f3);
        // shifts carry funct7 in the upper immediate bits and use only shamt
        if (f3 == 3'b001 || f3 == 3'b101) begin
          bundle.imm = imm_sh;
          if (f7 == F7_ALT && f3 == 3'b101) bundle.alu_op = ALU_SRA;
          else if (f7 != F7_BASE)           ill = 1'b1;
        end
      end
      OPC_LUI: begin
        bundle.alu_op  = ALU_LUI;
        bundle.imm     = imm_u;
        bundle.use_imm = 1'b1;
      end
      OPC_AUIPC: begin
        bundle.imm     = imm_u;
        bundle.use_imm = 1'b1;
        bundle.use_pc  = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    // illegal encodings degrade to ADD x0 so execute sees a harmless NOP
    if (ill) begin
      bundle.alu_op  = ALU_ADD;
      bundle.rd      = 5'd0;
      bundle.imm     = 32'd0;
      bundle.use_imm = 1'b1;
      bundle.use_pc  = 1'b0;
    end
`ifdef ALU_DEC_ILLEGAL_EN
    bundle.illegal = ill;
`else
    bundle.illegal = 1'b0;
`endif
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage: registered decoded bundle plus one-entry skid buffer, with flush.
// Illegal-flag reporting is enabled by defining ALU_DEC_ILLEGAL_EN.
module alu_decode_stage
  import alu_decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_instr,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [3:0]      o_alu_op,
  output logic [4:0]      o_rs1_addr,
  output logic [4:0]      o_rs2_addr,
  output logic [4:0]      o_rd_addr,
  output logic [31:0]     o_imm,
  output logic            o_use_imm,
  output logic            o_use_pc,
  output logic [PC_W-1:0] o_pc,
  output logic            o_illegal
);

  dec_bundle_t dec_p0;
  dec_bundle_t out_p1;
  dec_bundle_t skid_p1;
  logic        vld_p1;
  logic        skid_vld_p1;
  logic        rdy_q;
  logic        in_fire;
  logic        out_fire;
  logic        load_out;

  alu_dec_comb u_dec (
    .instr  (i_instr[31:0]),
    .pc     (DEC_PC_W'(i_pc)),
    .bundle (dec_p0)
  );

  assign in_fire  = i_valid & rdy_q;
  assign out_fire = vld_p1 & i_ready;
  assign load_out = ~vld_p1 | out_fire;

  // ---- stage p0 -> p1: output register and skid entry ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_p1      <= '0;
      skid_p1     <= '0;
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      rdy_q       <= 1'b1;
    end else if (i_flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      rdy_q       <= 1'b1;
    end else if (load_out) begin
      // o_ready is low whenever the skid is full, so no input can fire here then
      if (skid_vld_p1) begin
        out_p1      <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
        rdy_q       <= 1'b1;
      end else begin
        vld_p1 <= in_fire;
        if (in_fire) out_p1 <= dec_p0;
      end
    end else if (in_fire) begin
      skid_p1     <= dec_p0;
      skid_vld_p1 <= 1'b1;
      rdy_q       <= 1'b0;
    end
  end

  assign o_ready    = rdy_q;
  assign o_valid    = vld_p1;
  assign o_alu_op   = out_p1.alu_op;
  assign o_rs1_addr = out_p1.rs1;
  assign o_rs2_addr = out_p1.rs2;
  assign o_rd_addr  = out_p1.rd;
  assign o_imm      = out_p1.imm;
  assign o_use_imm  = out_p1.use_imm;
  assign o_use_pc   = out_p1.use_pc;
  assign o_pc       = PC_W'(out_p1.pc);
  assign o_illegal  = out_p1.illegal;

endmodule
